// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell shared over WIDTH cycles, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, FIN} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sacc_q, s_q;
  logic             c_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             bit_d, c_d, last_d;
  logic [WIDTH-1:0] sacc_d;
  // Full-adder cell as two half adders with the carries ORed
  always_comb begin
    bit_d  = sa_q[0] ^ sb_q[0] ^ c_q;
    c_d    = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    sacc_d = {bit_d, sacc_q[WIDTH-1:1]};
    last_d = cnt_q == CW'(WIDTH - 1);
  end
  // Sequencer: capture operands, shift one bit per cycle, publish the result on the final bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sacc_q  <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          sa_q    <= a_i;
          sb_q    <= b_i;
          c_q     <= cin_i;
          cnt_q   <= '0;
          sacc_q  <= '0;
          state_q <= ADD;
        end
        ADD: begin
          c_q    <= c_d;
          sacc_q <= sacc_d;
          sa_q   <= sa_q >> 1;
          sb_q   <= sb_q >> 1;
          cnt_q  <= last_d ? '0 : cnt_q + 1'b1;
          if (last_d) begin
            s_q     <= sacc_d;
            cout_q  <= c_d;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = state_q == ADD;
  assign done_o = state_q == FIN;
  assign s_o    = s_q;
  assign cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed scoreboard bench for the bit-serial adder controller
module tb_serial_adder_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a = '0, b = '0, s;
  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  int         tests = 0, fails = 0;
  logic [8:0] sb[$];

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy), .done_o(done), .s_o(s), .cout_o(cout)
  );
  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
    .busy_o(busy4), .done_o(done4), .s_o(s4), .cout_o(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every DONE pops the oldest expected sum and compares it
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_done: observed DONE=1 expected no pending operation");
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("sum", {23'd0, cout, s}, {23'd0, e});
      end
    end
  end

  task automatic add_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input string tag);
    int n, nb;
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
    sb.push_back(9'(ai) + 9'(bi) + 9'(ci));
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    n = 0; nb = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, nb, 8);
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_s", {24'd0, s}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    add_op(8'h00, 8'h00, 1'b0, "t1");
    add_op(8'h3C, 8'h42, 1'b0, "t2");
    add_op(8'hFF, 8'h01, 1'b0, "t3a");
    add_op(8'h5A, 8'hA5, 1'b1, "t3b");
    add_op(8'hC3, 8'h7E, 1'b1, "t3c");
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      check("t4_done", {31'd0, done}, 32'(t % 10 == 9));
      check("t4_busy", {31'd0, busy}, 32'(t % 10 >= 1 && t % 10 <= 8));
      start = 1'b1;
      if (t % 10 == 0) begin
        a = 8'h0F; b = 8'h01; cin = 1'b0;
        sb.push_back(9'h010);
      end else begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("t4_s_held", {24'd0, s}, 32'h10);
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    sb.push_back(9'h100);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_s", {24'd0, s}, 0);
    check("t5_cout", {31'd0, cout}, 0);
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      check("t5_no_done", {31'd0, done}, 0);
    end
    add_op(8'h01, 8'h02, 1'b0, "t5b");
    begin
      int n, nb;
      @(negedge clk);
      a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
      n = 0; nb = 0;
      while (done4 !== 1'b1 && n < 20) begin
        if (busy4 === 1'b1) nb++;
        @(negedge clk);
        n++;
      end
      check("t6_latency", n, 4);
      check("t6_busy_cycles", nb, 4);
      check("t6_s", {28'd0, s4}, 32'h1);
      check("t6_cout", {31'd0, cout4}, 1);
    end
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Sequences one 1-bit full-adder cell (two half adders plus an OR on the carries) over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the result register.
- Intended as the area-minimal adder option: one cell, shared over time, instead of WIDTH cells in parallel.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is WIDTH ≥ 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request to begin an addition; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on the accepting edge.
- B  in  WIDTH  operand B; captured on the accepting edge.
- CIN  in  1  carry-in; captured on the accepting edge.
- BUSY  out  1  high while an addition is in progress (state ADD).
- DONE  out  1  one-cycle pulse; result valid.
- S  out  WIDTH  registered sum.
- COUT  out  1  registered carry-out.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: state=IDLE, BUSY=0, DONE=0, S=0, COUT=0. Shift registers, carry flip-flop and counter are all cleared.
- Reset mid-operation: abort immediately. No DONE pulse. S and COUT read 0 after reset.
- States: IDLE, ADD, FIN. Encoding is free. BUSY = (state==ADD). DONE = (state==FIN), decoded Moore-style from state.
- IDLE, START=0: stay in IDLE.
- IDLE, START=1: on the edge,
  - load sa<=A, sb<=B, c<=CIN, cnt<=0, sacc<=0;
  - go to ADD.
- ADD, each edge:
  - compute bit = sa[0]^sb[0]^c;
  - c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0]));
  - sacc <= {bit, sacc[WIDTH-1:1]}; sa and sb shift right by one, zero-fill;
  - cnt <= cnt+1.
- ADD exit: on the edge where cnt==WIDTH-1,
  - load S <= {bit, sacc[WIDTH-1:1]} and COUT <= the new carry value;
  - go to FIN.
- FIN: DONE=1 for exactly one cycle, then unconditionally return to IDLE.
- START behaviour outside IDLE: ignored in ADD and in FIN. An acceptance can never occur in FIN.
- Latency: START accepted at edge k. The ADD state spans edges k+1..k+WIDTH. S, COUT and DONE are visible from edge k+WIDTH. DONE drops at edge k+WIDTH+1. Minimum START-to-START spacing is WIDTH+2 cycles.
- Result holding: S and COUT hold their last result until the next completion or reset. They never show partial sums. Intermediate bits live only in sacc.
- Operand stability: A, B and CIN may change freely after acceptance without affecting the running addition.
- Arithmetic: {COUT,S} == A + B + CIN, exact, unsigned, modulo 2^(WIDTH+1).
- Counter: cnt is $clog2(WIDTH) bits wide. It never wraps inside one operation.
- START held high continuously:
  - a new addition starts on the first IDLE edge after FIN;
  - exactly one DONE is produced per accepted operation.

Test Plan:
1. WIDTH=8, A=0x00, B=0x00, CIN=0, START pulsed one cycle → BUSY high for 8 cycles, then DONE for 1 cycle, S=0x00, COUT=0.
2. A=0x3C, B=0x42, CIN=0 → S=0x7E, COUT=0. DONE is observed exactly 8 edges after the accepting edge.
3. A=0xFF, B=0x01, CIN=0 → S=0x00, COUT=1. Then A=0x5A, B=0xA5, CIN=1 → S=0x00, COUT=1.
4. START held high for 30 cycles with A=0x0F, B=0x01 →
   - DONE pulses every 10 cycles;
   - START is ignored during BUSY/FIN;
   - S=0x10 on each DONE;
   - changing A/B during BUSY does not alter the in-flight result.
5. Start A=0x80, B=0x80. Drop RST_N asynchronously mid-cycle after 4 ADD cycles → BUSY=0, S=0, COUT=0 immediately, and no DONE ever appears. After release, a fresh A=0x01, B=0x02 gives S=0x03.
6. Parameter override WIDTH=4, A=0xF, B=0x1, CIN=1 → BUSY for 4 cycles, S=0x1, COUT=1.
